// File: rtl/clk_gen_pkg.sv
// Shared types and helpers for the clock-enable generator: channel FSM states,
// default divider width and the split of a divide value into low/high phases.
package clk_gen_pkg;

    localparam int DIV_W_DFLT = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2
    } ch_state_e;

    typedef struct packed {
        logic [31:0] lo;
        logic [31:0] hi;
    } div_half_t;

    // D of 0 or 1 is treated as 2 so that every period has at least one low and one high cycle.
    function automatic div_half_t div_halves(input logic [31:0] d);
        div_half_t   h;
        logic [31:0] deff;
        deff = (d < 32'd2) ? 32'd2 : d;
        h.lo = deff >> 1;
        h.hi = deff - h.lo;
        return h;
    endfunction

endpackage

// File: rtl/clk_div_ch.sv
// One divider channel: shadow register, pending flag, IDLE/LOW/HIGH FSM and
// phase counter. All outputs are registered from next-state values.
module clk_div_ch
    import clk_gen_pkg::*;
#(
    parameter int DIV_W    = DIV_W_DFLT,
    parameter int DIV_INIT = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             hold_i,
    input  logic             en_i,
    input  logic             wr_i,
    input  logic [DIV_W-1:0] wr_val_i,
    output logic             div_clk_o,
    output logic             tick_rise_o,
    output logic             tick_fall_o,
    output logic             upd_pend_o
);

    localparam logic [DIV_W-1:0] INIT_VAL = DIV_W'(DIV_INIT);

    ch_state_e        state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] shadow_q, shadow_d;
    logic [DIV_W-1:0] act_q, act_d;
    logic             pend_q, pend_d;
    logic             clk_q, rise_q, fall_q;
    div_half_t        h_shadow, h_act;

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        h_shadow = div_halves(32'(shadow_q));
        h_act    = div_halves(32'(act_q));
        state_d  = state_q;
        cnt_d    = cnt_q;
        act_d    = act_q;
        shadow_d = shadow_q;
        pend_d   = pend_q;

        if (wr_i) begin
            shadow_d = wr_val_i;
            pend_d   = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (en_i && !hold_i) begin
                    state_d = ST_LOW;
                    act_d   = shadow_q;
                    cnt_d   = DIV_W'(h_shadow.lo - 32'd1);
                    pend_d  = wr_i;
                end
            end
            ST_LOW: begin
                if (cnt_q == '0) begin
                    state_d = ST_HIGH;
                    cnt_d   = DIV_W'(h_act.hi - 32'd1);
                end else begin
                    cnt_d = cnt_q - DIV_W'(1);
                end
            end
            ST_HIGH: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - DIV_W'(1);
                end else if (en_i && !hold_i) begin
                    // A write landing on this boundary stays pending for the next one.
                    state_d = ST_LOW;
                    act_d   = shadow_q;
                    cnt_d   = DIV_W'(h_shadow.lo - 32'd1);
                    pend_d  = wr_i;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (hold_i) state_d = ST_IDLE;
    end

    // NOTE: sequential state uses non-blocking assignments only; every register,
    // including the shadow, has a defined reset value.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            shadow_q <= INIT_VAL;
            act_q    <= INIT_VAL;
            pend_q   <= 1'b0;
            clk_q    <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            act_q    <= act_d;
            pend_q   <= pend_d;
            clk_q    <= (state_d == ST_HIGH);
            rise_q   <= (state_d == ST_HIGH) && (state_q == ST_LOW);
            fall_q   <= (state_d == ST_HIGH) && (cnt_d == '0);
        end
    end

    assign div_clk_o   = clk_q;
    assign tick_rise_o = rise_q;
    assign tick_fall_o = fall_q;
    assign upd_pend_o  = pend_q;

endmodule

// File: rtl/clk_en_gen.sv
// Clock-enable generator top: PLL lock synchroniser, lock-stable counter driving
// the downstream reset, divider write decode and NUM_CH divider channels.
module clk_en_gen
    import clk_gen_pkg::*;
#(
    parameter int NUM_CH   = 2,
    parameter int DIV_W    = DIV_W_DFLT,
    parameter int DIV_INIT = 8,
    parameter int LOCK_CYC = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pll_lock,
    input  logic              div_wr,
    input  logic [2:0]        div_wr_ch,
    input  logic [DIV_W-1:0]  div_wr_val,
    input  logic [NUM_CH-1:0] ch_en,
    output logic              rst_out,
    output logic [NUM_CH-1:0] div_clk,
    output logic [NUM_CH-1:0] tick_rise,
    output logic [NUM_CH-1:0] tick_fall,
    output logic [NUM_CH-1:0] upd_pend
);

    localparam int             LCW      = $clog2(LOCK_CYC + 1);
    localparam logic [LCW-1:0] LOCK_MAX = LCW'(LOCK_CYC);

    logic           sync1_q, sync2_q;
    logic [LCW-1:0] lock_cnt_q, lock_cnt_d;
    logic           rst_out_q, rst_out_d;
    logic           hold;

    always_comb begin
        lock_cnt_d = lock_cnt_q;
        if (!sync2_q) begin
            lock_cnt_d = '0;
        end else if (lock_cnt_q < LOCK_MAX) begin
            lock_cnt_d = lock_cnt_q + LCW'(1);
        end
        rst_out_d = reset || (lock_cnt_d < LOCK_MAX);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            lock_cnt_q <= '0;
            rst_out_q  <= 1'b1;
        end else begin
            sync1_q    <= pll_lock;
            sync2_q    <= sync1_q;
            lock_cnt_q <= lock_cnt_d;
            rst_out_q  <= rst_out_d;
        end
    end

    assign rst_out = rst_out_q;
    // Channels idle in the same cycle rst_out rises and may only start once it has been low.
    assign hold    = rst_out_q | rst_out_d;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        clk_div_ch #(
            .DIV_W    (DIV_W),
            .DIV_INIT (DIV_INIT)
        ) u_ch (
            .clk         (clk),
            .reset       (reset),
            .hold_i      (hold),
            .en_i        (ch_en[i]),
            .wr_i        (div_wr && (div_wr_ch == 3'(i))),
            .wr_val_i    (div_wr_val),
            .div_clk_o   (div_clk[i]),
            .tick_rise_o (tick_rise[i]),
            .tick_fall_o (tick_fall[i]),
            .upd_pend_o  (upd_pend[i])
        );
    end

endmodule

// File: tb/tb_clk_en_gen.sv
// Directed bench for clk_en_gen: lock release, divide ratios, shadow update,
// write/boundary collision, disable mid-period and reset mid-operation.
module tb_clk_en_gen;

    localparam int NUM_CH   = 2;
    localparam int DIV_W    = 16;
    localparam int DIV_INIT = 8;
    localparam int LOCK_CYC = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              pll_lock;
    logic              div_wr;
    logic [2:0]        div_wr_ch;
    logic [DIV_W-1:0]  div_wr_val;
    logic [NUM_CH-1:0] ch_en;
    logic              rst_out;
    logic [NUM_CH-1:0] div_clk;
    logic [NUM_CH-1:0] tick_rise;
    logic [NUM_CH-1:0] tick_fall;
    logic [NUM_CH-1:0] upd_pend;

    int n_pass = 0;
    int n_chk  = 0;

    clk_en_gen #(
        .NUM_CH   (NUM_CH),
        .DIV_W    (DIV_W),
        .DIV_INIT (DIV_INIT),
        .LOCK_CYC (LOCK_CYC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pll_lock   (pll_lock),
        .div_wr     (div_wr),
        .div_wr_ch  (div_wr_ch),
        .div_wr_val (div_wr_val),
        .ch_en      (ch_en),
        .rst_out    (rst_out),
        .div_clk    (div_clk),
        .tick_rise  (tick_rise),
        .tick_fall  (tick_fall),
        .upd_pend   (upd_pend)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input int ch, input int val);
        div_wr     = 1'b1;
        div_wr_ch  = 3'(ch);
        div_wr_val = DIV_W'(val);
        step(1);
        div_wr     = 1'b0;
    endtask

    // Expected {div_clk, tick_rise, tick_fall} k cycles after the enable/reload edge.
    function automatic logic [2:0] model(input int k, input int d);
        int deff;
        int lo;
        int p;
        deff = (d < 2) ? 2 : d;
        lo   = deff / 2;
        p    = k % deff;
        return {p >= lo, p == lo, p == deff - 1};
    endfunction

    function automatic logic [2:0] obs_ch(input int ch);
        return {div_clk[ch], tick_rise[ch], tick_fall[ch]};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        int d;
        int base;
        int dlist[5];
        logic [2:0] e0;

        reset      = 1'b1;
        pll_lock   = 1'b0;
        div_wr     = 1'b0;
        div_wr_ch  = 3'd0;
        div_wr_val = '0;
        ch_en      = '0;
        step(2);
        check("reset_rst_out", rst_out, 1);
        check("reset_div_clk", div_clk, 0);
        check("reset_tick_rise", tick_rise, 0);
        check("reset_tick_fall", tick_fall, 0);
        check("reset_upd_pend", upd_pend, 0);

        // Lock release: rst_out falls 18 edges after pll_lock rises.
        reset    = 1'b0;
        pll_lock = 1'b1;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            step(1);
            n++;
            if (rst_out == 1'b0) break;
        end
        check("lock_release_cycles", n, 18);

        // One-cycle lock drop: rst_out rises on the third edge, then a full recount.
        pll_lock = 1'b0;
        step(1);
        pll_lock = 1'b1;
        check("lock_drop_edge1", rst_out, 0);
        step(1);
        check("lock_drop_edge2", rst_out, 0);
        step(1);
        check("lock_drop_edge3", rst_out, 1);
        n = 2;
        for (int i = 0; i < 40; i++) begin
            step(1);
            n++;
            if (rst_out == 1'b0) break;
        end
        check("lock_recount_cycles", n, 18);

        // Divide ratios on ch0.
        dlist = '{2, 3, 8, 1, 0};
        foreach (dlist[j]) begin
            d = dlist[j];
            wr(0, d);
            check($sformatf("ratio_d%0d_pend_set", d), upd_pend[0], 1);
            ch_en[0] = 1'b1;
            step(1);
            check($sformatf("ratio_d%0d_pend_clr", d), upd_pend[0], 0);
            for (int k = 0; k < 2 * ((d < 2) ? 2 : d) + 2; k++) begin
                check($sformatf("ratio_d%0d_k%0d", d, k), obs_ch(0), model(k, d));
                check($sformatf("ratio_d%0d_ch1_k%0d", d, k), obs_ch(1), 3'b000);
                step(1);
            end
            ch_en[0] = 1'b0;
            step(20);
        end

        // Glitch-free update (write 3 mid-high of D=8) then collision (write 5 on tick_fall).
        wr(0, 8);
        ch_en[0] = 1'b1;
        step(1);
        for (int k = 0; k < 30; k++) begin
            if (k < 8) begin
                d = 8; base = 0;
            end else if (k < 20) begin
                d = 3; base = 8;
            end else begin
                d = 5; base = 20;
            end
            check($sformatf("update_k%0d", k), obs_ch(0), model(k - base, d));
            check($sformatf("update_pend_k%0d", k), upd_pend[0],
                  ((k >= 6 && k < 8) || (k >= 17 && k < 20)) ? 1 : 0);
            if (k == 5 || k == 16) begin
                div_wr     = 1'b1;
                div_wr_ch  = 3'd0;
                div_wr_val = (k == 5) ? DIV_W'(3) : DIV_W'(5);
            end else begin
                div_wr = 1'b0;
            end
            step(1);
        end
        div_wr   = 1'b0;
        ch_en[0] = 1'b0;
        step(20);

        // Disable ch0 during LOW, re-enable later; ch1 (D=8) runs undisturbed.
        ch_en = 2'b11;
        step(1);
        for (int k = 0; k < 26; k++) begin
            if (k <= 4) e0 = model(k, 5);
            else if (k < 10) e0 = 3'b000;
            else e0 = model(k - 10, 5);
            check($sformatf("disable_ch0_k%0d", k), obs_ch(0), e0);
            check($sformatf("disable_ch1_k%0d", k), obs_ch(1), model(k, 8));
            if (k == 1) ch_en[0] = 1'b0;
            if (k == 9) ch_en[0] = 1'b1;
            step(1);
        end

        // Reset during HIGH with a pending write on ch1.
        wr(1, 4);
        check("pre_reset_pend", upd_pend, 2'b10);
        for (int i = 0; i < 10; i++) begin
            if (div_clk[0]) break;
            step(1);
        end
        check("pre_reset_in_high", div_clk[0], 1);
        reset = 1'b1;
        ch_en = 2'b00;
        step(1);
        reset = 1'b0;
        check("mid_reset_div_clk", div_clk, 0);
        check("mid_reset_rst_out", rst_out, 1);
        check("mid_reset_upd_pend", upd_pend, 0);
        check("mid_reset_ticks", {tick_rise, tick_fall}, 0);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            step(1);
            if (rst_out == 1'b0) begin
                n = 1;
                break;
            end
        end
        check("relock_after_reset", n, 1);

        // Out-of-range channel write is ignored; both shadows are back at DIV_INIT.
        wr(5, 3);
        check("bad_ch_pend", upd_pend, 0);
        ch_en = 2'b11;
        step(1);
        for (int k = 0; k < 18; k++) begin
            check($sformatf("init_ch0_k%0d", k), obs_ch(0), model(k, DIV_INIT));
            check($sformatf("init_ch1_k%0d", k), obs_ch(1), model(k, DIV_INIT));
            step(1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
